// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall/flush sequencer for the five-stage pipeline. It handles
//               load-use, flag-use, branch redirect, memory wait and HLT drain.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_W     = 4,
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_is_br,
    input  logic             id_halt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_set_flags,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_wen,
    output logic             if_id_wen,
    output logic             id_ex_wen,
    output logic             ex_mem_wen,
    output logic             mem_wb_wen,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_DRAIN  = 2'd1;
    localparam logic [1:0] c_ST_HALTED = 2'd2;

    localparam int c_DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) + 1 : 1;
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(DRAIN_CYC - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [c_DRAIN_W-1:0] r_drain_cnt;
    logic [c_DRAIN_W-1:0] w_drain_nxt;
    logic [CNT_W-1:0]     r_stall_cnt;
    logic                 r_halted;
    logic                 w_mstall;
    logic                 w_luse;
    logic                 w_fuse;
    logic [4:0]           w_wen;
    logic                 w_if_id_flush;
    logic                 w_id_ex_flush;

    assign w_mstall = mem_req & ~mem_ready;
    assign w_luse   = ex_mem_read & (ex_rd != '0) &
                      ((id_rs_used & (id_rs == ex_rd)) | (id_rt_used & (id_rt == ex_rd)));
    assign w_fuse   = id_is_br & ex_set_flags;

    // w_wen order: {pc, if_id, id_ex, ex_mem, mem_wb}
    always_comb begin
        w_wen         = 5'b00000;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_state_nxt   = r_state;
        w_drain_nxt   = r_drain_cnt;
        case (r_state)
            c_ST_RUN: begin
                if (w_mstall) begin
                    w_wen = 5'b00000;
                end else if (ex_br_taken) begin
                    w_wen         = 5'b11111;
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                end else if (w_luse | w_fuse) begin
                    w_wen         = 5'b00111;
                    w_id_ex_flush = 1'b1;
                end else if (id_halt) begin
                    w_wen       = 5'b11111;
                    w_state_nxt = c_ST_DRAIN;
                    w_drain_nxt = '0;
                end else begin
                    w_wen = 5'b11111;
                end
            end
            c_ST_DRAIN: begin
                if (!w_mstall) begin
                    w_wen         = 5'b00111;
                    w_id_ex_flush = 1'b1;
                    w_drain_nxt   = r_drain_cnt + c_DRAIN_W'(1);
                    if (r_drain_cnt == c_DRAIN_LAST) begin
                        w_state_nxt = c_ST_HALTED;
                    end
                end
            end
            c_ST_HALTED: begin
                w_state_nxt = c_ST_HALTED;
            end
            default: begin
                w_state_nxt = c_ST_RUN;
            end
        endcase
        // Everything is held while reset is asserted, whatever state decodes to.
        if (rst) begin
            w_wen         = 5'b00000;
            w_if_id_flush = 1'b0;
            w_id_ex_flush = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_RUN;
            r_drain_cnt <= '0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
            r_halted    <= (w_state_nxt == c_ST_HALTED);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == c_ST_RUN) && !w_wen[4] && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign pc_wen      = w_wen[4];
    assign if_id_wen   = w_wen[3];
    assign id_ex_wen   = w_wen[2];
    assign ex_mem_wen  = w_wen[1];
    assign mem_wb_wen  = w_wen[0];
    assign if_id_flush = w_if_id_flush;
    assign id_ex_flush = w_id_ex_flush;
    assign halted      = r_halted;
    assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed and random checks of pipe_hazard_ctrl against a
//               rule-level reference model of the hazard sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int REG_W     = 4;
    localparam int DRAIN_CYC = 3;
    localparam int CNT_W     = 5;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_rs_used;
    logic             id_rt_used;
    logic             id_is_br;
    logic             id_halt;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rd;
    logic             ex_set_flags;
    logic             ex_br_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_wen;
    logic             if_id_wen;
    logic             id_ex_wen;
    logic             ex_mem_wen;
    logic             mem_wb_wen;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Model: 0 = running, 1 = draining, 2 = halted
    int m_mode;
    int m_drained;
    int m_cnt;
    bit m_halted;

    pipe_hazard_ctrl #(
        .REG_W    (REG_W),
        .DRAIN_CYC(DRAIN_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_used  (id_rs_used),
        .id_rt_used  (id_rt_used),
        .id_is_br    (id_is_br),
        .id_halt     (id_halt),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .ex_set_flags(ex_set_flags),
        .ex_br_taken (ex_br_taken),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .pc_wen      (pc_wen),
        .if_id_wen   (if_id_wen),
        .id_ex_wen   (id_ex_wen),
        .ex_mem_wen  (ex_mem_wen),
        .mem_wb_wen  (mem_wb_wen),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .halted      (halted),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit f_mem_stall();
        return mem_req && !mem_ready;
    endfunction

    function automatic bit f_hazard();
        bit luse;
        luse = ex_mem_read && (ex_rd != 0) &&
               ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd));
        return luse || (id_is_br && ex_set_flags);
    endfunction

    // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
    function automatic logic [6:0] f_expect();
        if (rst || m_mode == 2 || f_mem_stall()) return 7'b0000000;
        if (m_mode == 1) return 7'b0011101;
        if (ex_br_taken) return 7'b1111111;
        if (f_hazard()) return 7'b0011101;
        return 7'b1111100;
    endfunction

    task automatic model_reset();
        m_mode    = 0;
        m_drained = 0;
        m_cnt     = 0;
        m_halted  = 0;
    endtask

    // Advance the model across one rising edge using the inputs held now.
    task automatic model_step();
        logic [6:0] e;
        e = f_expect();
        if (rst) begin
            model_reset();
        end else if (m_mode == 0) begin
            if (e[6] == 1'b0 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (!f_mem_stall() && !ex_br_taken && !f_hazard() && id_halt) begin
                m_mode    = 1;
                m_drained = 0;
            end
        end else if (m_mode == 1 && !f_mem_stall()) begin
            m_drained = m_drained + 1;
            if (m_drained == DRAIN_CYC) begin
                m_mode   = 2;
                m_halted = 1;
            end
        end
    endtask

    task automatic check_now(input string tag);
        logic [6:0] a;
        logic [6:0] e;
        e = f_expect();
        a = {pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen, if_id_flush, id_ex_flush};
        checks++;
        assert (a === e) else begin
            errors++;
            $error("FAIL %s ctl: got %b want %b", tag, a, e);
        end
        checks++;
        assert (stall_cnt === CNT_W'(m_cnt)) else begin
            errors++;
            $error("FAIL %s stall_cnt: got %0d want %0d", tag, stall_cnt, m_cnt);
        end
        checks++;
        assert (halted === m_halted) else begin
            errors++;
            $error("FAIL %s halted: got %b want %b", tag, halted, m_halted);
        end
    endtask

    // Inputs are stable from posedge+1; check at negedge, then cross the edge.
    task automatic cycle(input string tag);
        @(negedge clk);
        check_now(tag);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        id_rs        = '0;
        id_rt        = '0;
        id_rs_used   = 1'b0;
        id_rt_used   = 1'b0;
        id_is_br     = 1'b0;
        id_halt      = 1'b0;
        ex_mem_read  = 1'b0;
        ex_rd        = '0;
        ex_set_flags = 1'b0;
        ex_br_taken  = 1'b0;
        mem_req      = 1'b0;
        mem_ready    = 1'b0;
    endtask

    task automatic assert_rst();
        rst = 1'b1;
        model_reset();
        #1;
    endtask

    initial begin
        int n;
        clr_inputs();
        model_reset();
        rst = 1'b1;
        #1;
        cycle("reset");
        cycle("reset");
        rst = 1'b0;
        cycle("idle");

        // Load-use on rs
        ex_mem_read = 1'b1; ex_rd = 4'd3; id_rs = 4'd3; id_rs_used = 1'b1;
        cycle("luse");
        clr_inputs();
        cycle("luse_clear");

        // Load into R0 never stalls
        ex_mem_read = 1'b1; ex_rd = 4'd0; id_rs = 4'd0; id_rs_used = 1'b1;
        id_rt = 4'd0; id_rt_used = 1'b1;
        cycle("load_r0");
        clr_inputs();

        // Flag-use, then the same hazard with a redirect
        id_is_br = 1'b1; ex_set_flags = 1'b1;
        cycle("fuse");
        ex_br_taken = 1'b1;
        cycle("fuse_br");
        clr_inputs();

        // Memory wait holds a taken branch until release
        mem_req = 1'b1; mem_ready = 1'b0; ex_br_taken = 1'b1;
        repeat (4) cycle("mwait");
        mem_ready = 1'b1;
        cycle("mwait_rel");
        clr_inputs();
        checks++;
        assert (stall_cnt === CNT_W'(6)) else begin
            errors++;
            $error("FAIL stall_after_mwait: got %0d want 6", stall_cnt);
        end

        // HLT drain with a two-cycle memory wait in the middle
        id_halt = 1'b1;
        cycle("hlt_entry");
        clr_inputs();
        n = 0;
        while (!halted && n < 20) begin
            mem_req   = (n == 1 || n == 2);
            mem_ready = 1'b0;
            cycle("drain");
            n++;
        end
        clr_inputs();
        checks++;
        assert (n == DRAIN_CYC + 2) else begin
            errors++;
            $error("FAIL halt_latency: got %0d want %0d", n, DRAIN_CYC + 2);
        end
        ex_br_taken = 1'b1; id_halt = 1'b1;
        repeat (2) cycle("halted");
        clr_inputs();

        // Reset pulse mid-drain
        assert_rst();
        cycle("rst_halted");
        rst = 1'b0;
        ex_mem_read = 1'b1; ex_rd = 4'd5; id_rt = 4'd5; id_rt_used = 1'b1;
        cycle("luse_rt");
        clr_inputs();
        id_halt = 1'b1;
        cycle("hlt2");
        clr_inputs();
        cycle("drain2");
        assert_rst();
        check_now("rst_async");
        cycle("rst_hold");
        rst = 1'b0;
        cycle("after_rst");

        // Saturation of the stall counter
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (CNT_MAX - 1) cycle("preload");
        repeat (3) cycle("sat");
        clr_inputs();
        checks++;
        assert (stall_cnt === CNT_W'(CNT_MAX)) else begin
            errors++;
            $error("FAIL saturate: got %0d want %0d", stall_cnt, CNT_MAX);
        end

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                assert_rst();
            end else begin
                rst = 1'b0;
            end
            id_rs        = REG_W'($urandom_range(0, 3));
            id_rt        = REG_W'($urandom_range(0, 3));
            id_rs_used   = 1'($urandom_range(0, 1));
            id_rt_used   = 1'($urandom_range(0, 1));
            id_is_br     = ($urandom_range(0, 3) == 0);
            id_halt      = ($urandom_range(0, 24) == 0);
            ex_mem_read  = ($urandom_range(0, 2) == 0);
            ex_rd        = REG_W'($urandom_range(0, 3));
            ex_set_flags = ($urandom_range(0, 2) == 0);
            ex_br_taken  = ($urandom_range(0, 5) == 0);
            mem_req      = ($urandom_range(0, 2) == 0);
            mem_ready    = ($urandom_range(0, 2) != 0);
            cycle("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
